mire_writer: RTL and testbench
==============================

Name: mire_writer

Overview:
- Wishbone master that writes a test pattern ("mire") into the SDRAM framebuffer read by the VGA controller. It is the writer end of the framebuffer path.
- Sits on the stream master port of the Wishbone interconnect and competes with the VGA reader for SDRAM. It releases the bus periodically so the arbiter can serve the VGA reader.
- Writes full frames continuously while enabled.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0)
BURST_LEN, 64, accepted writes before a mandatory one-cycle bus release (>=1)

Ports:
sys_clk  in  1  system clock (100 MHz)
sys_rst_n  in  1  asynchronous active-low reset
en  in  1  enable; level-sensitive
wshb_cyc  out  1  Wishbone cycle
wshb_stb  out  1  Wishbone strobe
wshb_we  out  1  write enable, constant 1 while cyc
wshb_sel  out  4  byte select, constant 4'hF
wshb_cti  out  3  cycle type, constant 3'b000 (classic)
wshb_bte  out  2  burst type, constant 2'b00
wshb_adr  out  32  byte address
wshb_dat_ms  out  32  write data
wshb_ack  in  1  slave acknowledge
wshb_err  in  1  slave error
wshb_rty  in  1  slave retry
frame_done  out  1  one-cycle pulse on completion of the last pixel of a frame
err_flag  out  1  sticky error indicator

Behaviour:
- Reset (sys_rst_n=0, asynchronous): state IDLE; cyc=stb=0; x=y=0; burst_cnt=0; adr=BASE_ADDR; dat=pattern(0,0)=32'h00FFFFFF; frame_done=0; err_flag=0. Deassertion is synchronous to sys_clk and handled by the upstream synchroniser.
- Counters: x is $clog2(HDISP) bits, y is $clog2(VDISP) bits, burst_cnt is $clog2(BURST_LEN+1) bits.
- Address: adr = BASE_ADDR + 4*(y*HDISP + x), 32-bit, registered, recomputed on every advance. An incremental +4 implementation is allowed; wrap restores BASE_ADDR.
- Pixel format: 32'h00RRGGBB. pattern(x,y) = 32'h00FFFFFF if x[3:0]==0 or y[3:0]==0, else 32'h00000000 (white grid, 16-pixel pitch).
- FSM:
  - IDLE: cyc=stb=0. Go to WRITE when en=1.
  - WRITE: cyc=stb=1; adr and dat held stable until a termination (ack, err or rty).
    - On ack or err: advance the pixel and increment burst_cnt.
    - Next state is IDLE if en=0; else PAUSE if burst_cnt reaches BURST_LEN (burst_cnt then cleared); else stay in WRITE.
    - Back-to-back acks in consecutive cycles must be sustained: one write per cycle.
    - On rty alone: no advance; go to PAUSE and retry the same pixel afterwards.
  - PAUSE: cyc=stb=0 for exactly one cycle; then WRITE if en=1, else IDLE.
- Pixel advance: x++. At x==HDISP-1: x=0, y++. At x==HDISP-1 and y==VDISP-1: x=y=0 and frame_done=1 in the following cycle for one cycle. The next frame starts immediately.
- Simultaneous ack and err: treated as ack with err_flag set. err alone sets err_flag and still advances (no retry).
- err_flag is cleared only by reset.
- en deasserted mid-transfer: the current write completes (cyc held until termination), then IDLE. Position (x,y) and burst_cnt are kept; writing resumes at the same pixel when en returns.
- burst_cnt is cleared on entry to IDLE.
- Latency: cyc asserts in the cycle after en is sampled high in IDLE.
- Combinational paths from ack to any output are not allowed; all outputs are registered.

Test Plan:
1. HDISP=32, VDISP=4, BURST_LEN=8, slave acks every cycle, en=1 -> writes at adr 0x0,0x4,...; a cyc=0 gap of exactly 1 cycle after every 8 acks; 128 writes per frame; frame_done pulses once per 128 acks, then adr returns to 0x0.
2. Data check, same config -> dat=0x00FFFFFF at (0,y), (16,y) and all of row 0; dat=0x00000000 at (1,1) adr 0x84 and at (5,3) adr 0x194.
3. Slave with 3 wait states per ack -> adr/dat/stb stable during waits; same address sequence as scenario 1; no skipped or duplicated pixel.
4. en dropped while stb is pending at pixel 10 -> cyc stays high until ack, then IDLE. Re-enable -> first write at adr 0x2C (pixel 11).
5. rty on pixel 5, then ack -> a 1-cycle cyc=0 gap, then pixel 5 (adr 0x14) is rewritten; err_flag=0. err on pixel 6 -> err_flag=1 and stays 1; the next write is adr 0x1C.
6. Assert sys_rst_n=0 mid-frame, asynchronously between clock edges -> cyc=stb=0 immediately. After release and en=1 -> first write at BASE_ADDR with data 0x00FFFFFF; frame_done=0 throughout reset.

Source files
------------

// File: rtl/mire_writer.sv
// mire_writer: Wishbone classic master that continuously fills the SDRAM
// framebuffer with a white 16-pixel grid on black ("mire").
//
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   en                 : level enable; writing pauses at a pixel boundary when low
//   wshb_*             : Wishbone master signals (classic single writes)
//   frame_done         : one-cycle pulse after the last pixel of a frame is written
//   err_flag           : sticky, set by any slave error, cleared only by reset
//
// The bus is released for one cycle after every BURST_LEN accepted writes and
// after every retry, giving the arbiter a chance to serve the VGA reader.
module mire_writer #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned BURST_LEN = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic        frame_done,
    output logic        err_flag
);

    localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [XW-1:0] X_LAST    = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(VDISP - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Grid pixel: white when on a 16-pixel column or row boundary.
    function automatic logic [31:0] pattern(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [15:0] xe;
        logic [15:0] ye;
        xe = 16'(px);
        ye = 16'(py);
        if ((xe[3:0] == 4'd0) || (ye[3:0] == 4'd0)) begin
            return 32'h00FF_FFFF;
        end else begin
            return 32'h0000_0000;
        end
    endfunction

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          frame_done_q, frame_done_d;
    logic          err_flag_q, err_flag_d;

    logic [XW-1:0] x_nxt_s;
    logic [YW-1:0] y_nxt_s;
    logic          wrap_s;
    logic [BW-1:0] burst_inc_s;

    // Raster position following the current one; wrap_s marks the frame's last pixel.
    always_comb begin
        if (x_q == X_LAST) begin
            x_nxt_s = {XW{1'b0}};
            if (y_q == Y_LAST) begin
                y_nxt_s = {YW{1'b0}};
                wrap_s  = 1'b1;
            end else begin
                y_nxt_s = y_q + YW'(1);
                wrap_s  = 1'b0;
            end
        end else begin
            x_nxt_s = x_q + XW'(1);
            y_nxt_s = y_q;
            wrap_s  = 1'b0;
        end
    end

    // Next-state logic for the FSM, raster counters and registered bus outputs.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        burst_d      = burst_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        frame_done_d = 1'b0;
        err_flag_d   = err_flag_q;
        burst_inc_s  = burst_q + BW'(1);
        case (state_q)
            S_IDLE: begin
                burst_d = {BW{1'b0}};
                if (en) begin
                    state_d = S_WRITE;
                    cyc_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                end
            end
            S_WRITE: begin
                if (wshb_ack || wshb_err) begin
                    // Error is not retried: the pixel is considered consumed.
                    x_d          = x_nxt_s;
                    y_d          = y_nxt_s;
                    adr_d        = wrap_s ? BASE_ADDR : (adr_q + 32'd4);
                    dat_d        = pattern(x_nxt_s, y_nxt_s);
                    frame_done_d = wrap_s;
                    if (wshb_err) begin
                        err_flag_d = 1'b1;
                    end else begin
                        err_flag_d = err_flag_q;
                    end
                    if (!en) begin
                        state_d = S_IDLE;
                        cyc_d   = 1'b0;
                        burst_d = {BW{1'b0}};
                    end else if (burst_inc_s == BURST_MAX) begin
                        state_d = S_PAUSE;
                        cyc_d   = 1'b0;
                        burst_d = {BW{1'b0}};
                    end else begin
                        state_d = S_WRITE;
                        cyc_d   = 1'b1;
                        burst_d = burst_inc_s;
                    end
                end else if (wshb_rty) begin
                    // Same pixel is reissued after the one-cycle release.
                    state_d = S_PAUSE;
                    cyc_d   = 1'b0;
                end else begin
                    state_d = S_WRITE;
                    cyc_d   = 1'b1;
                end
            end
            S_PAUSE: begin
                if (en) begin
                    state_d = S_WRITE;
                    cyc_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    burst_d = {BW{1'b0}};
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                burst_d = {BW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            x_q          <= {XW{1'b0}};
            y_q          <= {YW{1'b0}};
            burst_q      <= {BW{1'b0}};
            cyc_q        <= 1'b0;
            adr_q        <= BASE_ADDR;
            dat_q        <= 32'h00FF_FFFF;
            frame_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            burst_q      <= burst_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            frame_done_q <= frame_done_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign wshb_cyc    = cyc_q;
    assign wshb_stb    = cyc_q;
    assign wshb_we     = cyc_q;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign wshb_adr    = adr_q;
    assign wshb_dat_ms = dat_q;
    assign frame_done  = frame_done_q;
    assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_mire_writer.sv
// Testbench for mire_writer with a 32x4 frame and 8-write bursts.
module tb_mire_writer;

    localparam int H = 32;
    localparam int V = 4;
    localparam int NPIX = H * V;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        en;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_adr, wshb_dat_ms;
    logic        wshb_ack, wshb_err, wshb_rty;
    logic        frame_done, err_flag;

    mire_writer #(
        .HDISP(32), .VDISP(4), .BASE_ADDR(32'h0000_0000), .BURST_LEN(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
        .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we),
        .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
        .wshb_adr(wshb_adr), .wshb_dat_ms(wshb_dat_ms),
        .wshb_ack(wshb_ack), .wshb_err(wshb_err), .wshb_rty(wshb_rty),
        .frame_done(frame_done), .err_flag(err_flag)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          pix;
        logic [31:0] adr;
        logic [31:0] dat;
    } pix_vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // slave model state
    int          wait_states;
    int          wait_cnt;
    int          exp_pix;
    int          n_acc;
    int          last_fire;   // 0 none, 1 ack, 2 err, 3 rty
    logic        rty_pending, err_pending;
    logic [31:0] rty_adr, err_adr, hold_adr, hold_dat;
    logic [31:0] cap_adr [0:NPIX-1];
    logic [31:0] cap_dat [0:NPIX-1];
    pix_vec_t    vecs [0:11];
    int          found;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_dat(input int pix);
        int px, py;
        px = pix % H;
        py = pix / H;
        if ((px % 16 == 0) || (py % 16 == 0)) return 32'h00FF_FFFF;
        return 32'h0000_0000;
    endfunction

    // One clock: sample at the falling edge and decide the slave response
    // presented at the next rising edge.
    task automatic tick();
        @(negedge sys_clk);
        wshb_ack  = 1'b0;
        wshb_err  = 1'b0;
        wshb_rty  = 1'b0;
        last_fire = 0;
        if (wshb_stb) begin
            if (wait_cnt == wait_states) begin
                wait_cnt = 0;
                if (rty_pending && (wshb_adr == rty_adr)) begin
                    wshb_rty    = 1'b1;
                    rty_pending = 1'b0;
                    last_fire   = 3;
                end else begin
                    if (err_pending && (wshb_adr == err_adr)) begin
                        wshb_err    = 1'b1;
                        err_pending = 1'b0;
                        last_fire   = 2;
                    end else begin
                        wshb_ack  = 1'b1;
                        last_fire = 1;
                    end
                    check("wr_adr", wshb_adr, 32'(4 * exp_pix));
                    check("wr_dat", wshb_dat_ms, exp_dat(exp_pix));
                    if (n_acc < NPIX) begin
                        cap_adr[n_acc] = wshb_adr;
                        cap_dat[n_acc] = wshb_dat_ms;
                    end
                    n_acc++;
                    exp_pix = (exp_pix + 1) % NPIX;
                end
            end else begin
                if (wait_cnt == 0) begin
                    hold_adr = wshb_adr;
                    hold_dat = wshb_dat_ms;
                end else begin
                    check("hold_adr", wshb_adr, hold_adr);
                    check("hold_dat", wshb_dat_ms, hold_dat);
                end
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic reset_model();
        wait_cnt    = 0;
        exp_pix     = 0;
        n_acc       = 0;
        rty_pending = 1'b0;
        err_pending = 1'b0;
        rty_adr     = 32'h0;
        err_adr     = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        en        = 1'b0;
        wshb_ack  = 1'b0;
        wshb_err  = 1'b0;
        wshb_rty  = 1'b0;
        sys_rst_n = 1'b0;
        reset_model();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Tick until the DUT shows a strobe, failing if it never does.
    task automatic wait_stb(input string name, input int budget);
        found = 0;
        for (int i = 0; i < budget && found == 0; i++) begin
            tick();
            if (wshb_stb) found = 1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{0,   32'h000, 32'h00FF_FFFF};
        vecs[1]  = '{1,   32'h004, 32'h00FF_FFFF};
        vecs[2]  = '{5,   32'h014, 32'h00FF_FFFF};
        vecs[3]  = '{16,  32'h040, 32'h00FF_FFFF};
        vecs[4]  = '{31,  32'h07C, 32'h00FF_FFFF};
        vecs[5]  = '{32,  32'h080, 32'h00FF_FFFF};
        vecs[6]  = '{33,  32'h084, 32'h0000_0000};
        vecs[7]  = '{48,  32'h0C0, 32'h00FF_FFFF};
        vecs[8]  = '{49,  32'h0C4, 32'h0000_0000};
        vecs[9]  = '{96,  32'h180, 32'h00FF_FFFF};
        vecs[10] = '{101, 32'h194, 32'h0000_0000};
        vecs[11] = '{127, 32'h1FC, 32'h0000_0000};

        sys_rst_n   = 1'b0;
        en          = 1'b0;
        wshb_ack    = 1'b0;
        wshb_err    = 1'b0;
        wshb_rty    = 1'b0;
        wait_states = 0;
        reset_model();

        // Reset state
        do_reset();
        @(negedge sys_clk);
        check("rst_cyc", 32'(wshb_cyc), 32'd0);
        check("rst_stb", 32'(wshb_stb), 32'd0);
        check("rst_adr", wshb_adr, 32'h0);
        check("rst_dat", wshb_dat_ms, 32'h00FF_FFFF);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);

        // Zero-wait slave: 8-on/1-off bus pattern, frame_done every 128 writes
        en = 1'b1;
        wait_stb("s1_first_stb", 5);
        check("s1_we",  32'(wshb_we), 32'd1);
        check("s1_sel", 32'(wshb_sel), 32'hF);
        check("s1_cti", 32'(wshb_cti), 32'd0);
        check("s1_bte", 32'(wshb_bte), 32'd0);
        for (int k = 0; k < 288; k++) begin
            check("s1_burst_gap", 32'(wshb_stb), 32'((k % 9) != 8));
            check("s1_frame_done", 32'(frame_done), 32'((k == 143) || (k == 287)));
            if (k == 144) check("s1_wrap_adr", wshb_adr, 32'h0);
            tick();
        end

        // Captured first frame against hand-computed pixels
        for (int i = 0; i < 12; i++) begin
            check("s2_tab_adr", cap_adr[vecs[i].pix], vecs[i].adr);
            check("s2_tab_dat", cap_dat[vecs[i].pix], vecs[i].dat);
        end

        // Three wait states per write
        do_reset();
        wait_states = 3;
        en = 1'b1;
        for (int i = 0; i < 200 && n_acc < 20; i++) tick();
        check("s3_writes_done", 32'(n_acc), 32'd20);

        // en dropped while pixel 10 is pending
        do_reset();
        wait_states = 3;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (wshb_stb && (wshb_adr == 32'h28)) found = 1;
        end
        check("s4_reach_px10", 32'(found), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s4_cyc_held", 32'(wshb_cyc), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s4_idle_cyc", 32'(wshb_cyc), 32'd0);
        end
        check("s4_acc_count", 32'(n_acc), 32'd11);
        en = 1'b1;
        wait_stb("s4_resume_stb", 10);
        check("s4_resume_adr", wshb_adr, 32'h2C);

        // Retry on pixel 5, error on pixel 6
        do_reset();
        wait_states = 0;
        rty_pending = 1'b1;
        rty_adr     = 32'h14;
        err_pending = 1'b1;
        err_adr     = 32'h18;
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            tick();
            if (last_fire == 3) found = 1;
        end
        check("s5_rty_fired", 32'(found), 32'd1);
        tick();
        check("s5_rty_gap", 32'(wshb_cyc), 32'd0);
        tick();
        check("s5_retry_stb", 32'(wshb_stb), 32'd1);
        check("s5_retry_adr", wshb_adr, 32'h14);
        tick();
        check("s5_err_flag_clear", 32'(err_flag), 32'd0);
        check("s5_err_fired", 32'(last_fire), 32'd2);
        tick();
        check("s5_err_flag_set", 32'(err_flag), 32'd1);
        check("s5_after_err_adr", wshb_adr, 32'h1C);
        repeat (20) tick();
        check("s5_err_flag_sticky", 32'(err_flag), 32'd1);

        // Asynchronous reset mid-frame
        do_reset();
        wait_states = 0;
        en = 1'b1;
        repeat (50) tick();
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        wshb_ack  = 1'b0;
        en        = 1'b0;
        reset_model();
        #1;
        check("s6_async_cyc", 32'(wshb_cyc), 32'd0);
        check("s6_async_stb", 32'(wshb_stb), 32'd0);
        check("s6_async_adr", wshb_adr, 32'h0);
        check("s6_async_dat", wshb_dat_ms, 32'h00FF_FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("s6_rst_frame_done", 32'(frame_done), 32'd0);
        end
        sys_rst_n = 1'b1;
        en = 1'b1;
        wait_stb("s6_restart_stb", 5);
        check("s6_restart_adr", wshb_adr, 32'h0);
        check("s6_restart_dat", wshb_dat_ms, 32'h00FF_FFFF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
